// File: rtl/ysyx_22040125_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states, lane-mask and alignment helpers.
package ysyx_22040125_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  function automatic logic [7:0] gen_wmask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << off;
      SZ_W:    m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      SZ_D:    bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_align.sv
// Picks the addressed lane out of an aligned doubleword and sign/zero extends it to 64 bits.
module ysyx_22040125_lsu_align
  import ysyx_22040125_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [63:0] lane;
  logic        sx;

  assign lane = rdata >> {off, 3'b000};
  assign sx   = ~is_unsigned;

  always_comb begin
    data = lane;
    case (size)
      SZ_B:    data = {{56{sx & lane[7]}},  lane[7:0]};
      SZ_H:    data = {{48{sx & lane[15]}}, lane[15:0]};
      SZ_W:    data = {{32{sx & lane[31]}}, lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (RESP) -> DONE, stalls the pipe while busy.
module ysyx_22040125_lsu
  import ysyx_22040125_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_load,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign,
  output logic          stall
);

  lsu_state_t    state, state_nxt;
  logic          accept, misal, start;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q, store_q, misalign_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] wdata_q, wb_data_q, ext_data;
  logic [7:0]    wmask_q;

  assign accept = (state == IDLE) & req_valid & (req_load | req_store);
  assign misal  = is_misaligned(req_size, req_addr[2:0]);
  assign start  = accept & ~misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)      state_nxt = REQ;
      REQ:  if (mem_ready)  state_nxt = store_q ? DONE : RESP;
      RESP: if (mem_rvalid) state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Load has priority when both load and store are asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      misalign_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      misalign_q <= accept & misal;
      if (start) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        store_q <= ~req_load;
        rd_q    <= req_rd;
        wdata_q <= req_wdata;
        wmask_q <= req_load ? 8'h00 : gen_wmask(req_size, req_addr[2:0]);
      end
      if ((state == RESP) && mem_rvalid) wb_data_q <= ext_data;
    end
  end

  ysyx_22040125_lsu_align u_align (
    .rdata       (mem_rdata),
    .off         (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign mem_valid = (state == REQ);
  assign mem_we    = store_q;
  assign mem_addr  = {addr_q[AW-1:3], 3'b000};
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = (state == DONE);
  assign wb_we     = (state == DONE) & ~store_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Directed LSU bench: behavioural memory, expected-completion queue and a separate output monitor.
module tb_ysyx_22040125_lsu;
  import ysyx_22040125_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, req_load, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, mem_addr;
  logic [63:0] req_wdata, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  req_rd, wb_rd;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_we, misalign, stall;

  ysyx_22040125_lsu #(.AW(32), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .stall(stall)
  );

  typedef struct {
    bit          misal;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } memtx_t;

  exp_t        exp_q[$];
  memtx_t      mq[$];
  int          mon_ptr = 0;
  int          mq_ptr = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          mem_wait = 0;
  int          rd_lat = 0;
  int          mv_cycles = 0;
  logic [63:0] rd_val = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Memory: mem_ready after mem_wait cycles of mem_valid, read data rd_lat+1 cycles after handshake.
  initial begin
    int wait_cnt;
    int pend;
    memtx_t t;
    wait_cnt = 0;
    pend = 0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_val;
        end
      end
      if (mem_valid) begin
        mv_cycles++;
        if (wait_cnt >= mem_wait) begin
          mem_ready = 1'b1;
          wait_cnt = 0;
          t.addr = mem_addr;
          t.we = mem_we;
          t.wmask = mem_wmask;
          t.wdata = mem_wdata;
          mq.push_back(t);
          if (!mem_we) pend = rd_lat + 1;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid || misalign) begin
        if (mon_ptr >= exp_q.size()) begin
          check("unexpected_output", {62'd0, wb_valid, misalign}, 64'd0);
        end else begin
          e = exp_q[mon_ptr];
          mon_ptr++;
          check("sb_misalign", 64'(misalign), 64'(e.misal));
          check("sb_wb_valid", 64'(wb_valid), 64'(!e.misal));
          check("sb_latency", 64'(cyc - e.acc), 64'(e.lat));
          if (!e.misal) begin
            check("sb_wb_we", 64'(wb_we), 64'(e.we));
            if (e.we) begin
              check("sb_wb_rd", 64'(wb_rd), 64'(e.rd));
              check("sb_wb_data", wb_data, e.data);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input bit misal, input bit we, input logic [4:0] rd,
                          input logic [63:0] data, input int acc, input int lat);
    exp_t e;
    e.misal = misal; e.we = we; e.rd = rd; e.data = data; e.acc = acc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [63:0] wd, input logic [4:0] rd,
                       output int acc);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    check(name, 64'(stall), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic get_tx(output memtx_t t);
    check("memtx_present", 64'(mq.size() > mq_ptr), 64'd1);
    if (mq.size() > mq_ptr) begin
      t = mq[mq_ptr];
      mq_ptr++;
    end else begin
      t = '{default: '0};
    end
  endtask

  initial begin
    int acc, mv0;
    bit stall_seen;
    memtx_t t;
    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_size = SZ_B;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb", {61'd0, wb_valid, wb_we, misalign}, 64'd0);
    check("rst_mem_we_mask", {55'd0, mem_we, mem_wmask}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // lb, sign-extended byte 5
    rd_val = 64'h0000_80FF_0000_0000;
    issue(1, 0, SZ_B, 0, 32'h8000_0005, 64'd0, 5'd5, acc);
    push_exp(0, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, acc, 3);
    wait_idle("t1_done");
    get_tx(t);
    check("t1_mem_addr", 64'(t.addr), 64'h8000_0000);
    check("t1_mem_we", 64'(t.we), 64'd0);

    // lhu, top half
    rd_val = 64'hBEEF_0000_0000_0000;
    issue(1, 0, SZ_H, 1, 32'h8000_0006, 64'd0, 5'd6, acc);
    push_exp(0, 1, 5'd6, 64'h0000_0000_0000_BEEF, acc, 3);
    wait_idle("t2_done");
    get_tx(t);

    // sw with three wait cycles
    mem_wait = 3;
    mv0 = mv_cycles;
    issue(0, 1, SZ_W, 0, 32'h8000_0004, {2{32'hDEAD_BEEF}}, 5'd0, acc);
    push_exp(0, 0, 5'd0, 64'd0, acc, 5);
    wait_idle("t3_done");
    mem_wait = 0;
    check("t3_mem_valid_cycles", 64'(mv_cycles - mv0), 64'd4);
    get_tx(t);
    check("t3_wmask", 64'(t.wmask), 64'h00F0);
    check("t3_mem_addr", 64'(t.addr), 64'h8000_0000);
    check("t3_mem_we", 64'(t.we), 64'd1);
    check("t3_mem_wdata", t.wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    check("t3_wb_data_hold", wb_data, 64'h0000_0000_0000_BEEF);

    // misaligned ld
    mv0 = mv_cycles;
    issue(1, 0, SZ_D, 0, 32'h8000_0003, 64'd0, 5'd3, acc);
    push_exp(1, 0, 5'd0, 64'd0, acc, 1);
    stall_seen = stall;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stall_seen |= stall;
    end
    check("t4_stall_never", 64'(stall_seen), 64'd0);
    check("t4_no_mem_valid", 64'(mv_cycles - mv0), 64'd0);
    @(posedge clk); #1;

    // async reset during REQ drops mem_valid immediately
    mem_wait = 5;
    issue(0, 1, SZ_D, 0, 32'h8000_0008, 64'h1, 5'd0, acc);
    check("t5_req_mem_valid", 64'(mem_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_async_drop", {62'd0, mem_valid, stall}, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    mem_wait = 0;

    // lw reset in RESP, stale rvalid afterwards must be ignored
    rd_lat = 1;
    rd_val = 64'h1234_5678_9ABC_DEF0;
    issue(1, 0, SZ_W, 0, 32'h8000_0008, 64'd0, 5'd7, acc);
    @(posedge clk); #1;
    check("t5_in_resp", 64'(stall), 64'd1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rd_lat = 0;
    check("t5_req_ready", 64'(req_ready), 64'd1);
    check("t5_stall", 64'(stall), 64'd0);
    get_tx(t);

    // back-to-back sd then lwu
    rd_val = 64'hFFFF_FFFF_8765_4321;
    issue(0, 1, SZ_D, 0, 32'h8000_0000, 64'h1122_3344_5566_7788, 5'd0, acc);
    push_exp(0, 0, 5'd0, 64'd0, acc, 2);
    issue(1, 0, SZ_W, 1, 32'h8000_0000, 64'd0, 5'd9, acc);
    push_exp(0, 1, 5'd9, 64'h0000_0000_8765_4321, acc, 3);
    wait_idle("t6_done");
    get_tx(t);
    check("t6_sd_wmask", 64'(t.wmask), 64'h00FF);
    check("t6_sd_wdata", t.wdata, 64'h1122_3344_5566_7788);
    get_tx(t);
    check("t6_lwu_we", 64'(t.we), 64'd0);

    // load and store both set: load wins
    rd_val = 64'h8123_4567_89AB_CDEF;
    issue(1, 1, SZ_D, 0, 32'h8000_0010, 64'hFFFF, 5'd10, acc);
    push_exp(0, 1, 5'd10, 64'h8123_4567_89AB_CDEF, acc, 3);
    wait_idle("t7_done");
    get_tx(t);
    check("t7_load_wins_we", 64'(t.we), 64'd0);
    check("t7_mem_addr", 64'(t.addr), 64'h8000_0010);

    // signed lw from upper lane
    rd_val = 64'h8000_0001_0000_0000;
    issue(1, 0, SZ_W, 0, 32'h8000_0004, 64'd0, 5'd11, acc);
    push_exp(0, 1, 5'd11, 64'hFFFF_FFFF_8000_0001, acc, 3);
    wait_idle("t8_done");
    get_tx(t);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(mon_ptr), 64'(exp_q.size()));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
